// File: rtl/csr_access_sequencer_pkg.sv
// Shared encodings for the CSR access sequencer: FSM states, CSR address fields, privilege levels.
package csr_access_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRAP_WR = 3'd1,
        ST_READ    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_WRITE   = 3'd4,
        ST_RESP    = 3'd5
    } seq_state_t;

    localparam int CSR_PRIV_LSB = 8;
    localparam int CSR_PRIV_MSB = 9;
    localparam int CSR_RO_LSB   = 10;
    localparam int CSR_RO_MSB   = 11;
    localparam logic [1:0] CSR_RO_CODE = 2'b11;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    // Access is illegal when the CSR needs more privilege than we hold, or a modify hits a read-only CSR.
    function automatic logic csr_access_illegal(input logic [11:0] addr,
                                                input logic [1:0]  priv_lvl,
                                                input logic        modifies);
        return (addr[CSR_PRIV_MSB:CSR_PRIV_LSB] > priv_lvl) ||
               (modifies && (addr[CSR_RO_MSB:CSR_RO_LSB] == CSR_RO_CODE));
    endfunction

endpackage

// File: rtl/csr_rmw_unit.sv
// Combinational new-value computation for CSR read-modify-write; write beats set beats clear.
module csr_rmw_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] old_val,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  op_wr,
    input  logic                  op_set,
    input  logic                  op_clr,
    output logic [DATA_WIDTH-1:0] new_val
);

    always_comb begin
        new_val = old_val;
        if (op_wr) begin
            new_val = wdata;
        end else if (op_set) begin
            new_val = old_val | wdata;
        end else if (op_clr) begin
            new_val = old_val & ~wdata;
        end
    end

endmodule

// File: rtl/csr_access_sequencer.sv
// CSR read-modify-write sequencer arbitrating the CSR file between pipe ops and trap writes (traps win).
// Latency from accept: RMW 4, write-only 2, no-op/illegal 1 cycle; pipe stalls until pipe_done, traps wait for IDLE.
// Optional privilege/read-only checking is enabled by defining CSR_SEQ_PRIV_CHECK_EN.
module csr_access_sequencer
    import csr_access_sequencer_pkg::*;
#(
    parameter int unsigned CORE            = 0,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned SCAN_CYCLES_MIN = 0,
    parameter int unsigned SCAN_CYCLES_MAX = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pipe_valid,
    output logic                  pipe_ready,
    input  logic                  CSR_read_en,
    input  logic                  CSR_write_en,
    input  logic                  CSR_set_en,
    input  logic                  CSR_clear_en,
    input  logic [11:0]           pipe_addr,
    input  logic [DATA_WIDTH-1:0] pipe_wdata,
    input  logic [1:0]            priv,
    output logic                  pipe_done,
    output logic [DATA_WIDTH-1:0] pipe_rdata,
    output logic                  pipe_illegal,
    output logic                  stall,
    input  logic                  trap_valid,
    input  logic [11:0]           trap_addr,
    input  logic [DATA_WIDTH-1:0] trap_wdata,
    output logic                  trap_ready,
    output logic                  csr_rd_en,
    output logic [11:0]           csr_rd_addr,
    input  logic [DATA_WIDTH-1:0] csr_rd_data,
    output logic                  csr_wr_en,
    output logic [11:0]           csr_wr_addr,
    output logic [DATA_WIDTH-1:0] csr_wr_data,
    input  logic                  scan
);

    seq_state_t            state_q, state_d;
    logic                  op_rd_q, op_rd_d, op_wr_q, op_wr_d;
    logic                  op_set_q, op_set_d, op_clr_q, op_clr_d;
    logic                  ill_q, ill_d;
    logic [11:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, old_q, old_d;
    logic                  pipe_done_q, pipe_done_d, pipe_illegal_q, pipe_illegal_d;
    logic [DATA_WIDTH-1:0] pipe_rdata_q, pipe_rdata_d;
    logic                  csr_rd_en_q, csr_rd_en_d, csr_wr_en_q, csr_wr_en_d;
    logic [11:0]           csr_rd_addr_q, csr_rd_addr_d, csr_wr_addr_q, csr_wr_addr_d;
    logic [DATA_WIDTH-1:0] csr_wr_data_q, csr_wr_data_d;
    logic [31:0]           cycle_q, cycle_d;
    logic                  scan_hit_q, scan_hit_d;

    logic                  accept_trap, accept_pipe, illegal;
    logic [DATA_WIDTH-1:0] new_val;

    assign accept_trap = (state_q == ST_IDLE) & trap_valid & ~reset;
    assign accept_pipe = (state_q == ST_IDLE) & pipe_valid & ~trap_valid & ~reset;

`ifdef CSR_SEQ_PRIV_CHECK_EN
    assign illegal = csr_access_illegal(pipe_addr, priv, CSR_write_en | CSR_set_en | CSR_clear_en);
`else
    assign illegal = 1'b0;
`endif

    // Fed with next-state operands so the write data can be registered alongside csr_wr_en.
    csr_rmw_unit #(.DATA_WIDTH(DATA_WIDTH)) u_rmw (
        .old_val (old_d),
        .wdata   (wdata_d),
        .op_wr   (op_wr_d),
        .op_set  (op_set_d),
        .op_clr  (op_clr_d),
        .new_val (new_val)
    );

    always_comb begin
        state_d  = state_q;
        op_rd_d  = op_rd_q;
        op_wr_d  = op_wr_q;
        op_set_d = op_set_q;
        op_clr_d = op_clr_q;
        ill_d    = ill_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        old_d    = old_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_trap) begin
                    state_d  = ST_TRAP_WR;
                    {op_rd_d, op_wr_d, op_set_d, op_clr_d} = 4'b0000;
                    ill_d    = 1'b0;
                    addr_d   = trap_addr;
                    wdata_d  = trap_wdata;
                    old_d    = '0;
                end else if (accept_pipe) begin
                    {op_rd_d, op_wr_d, op_set_d, op_clr_d} = {CSR_read_en, CSR_write_en, CSR_set_en, CSR_clear_en};
                    ill_d    = illegal;
                    addr_d   = pipe_addr;
                    wdata_d  = pipe_wdata;
                    old_d    = '0;
                    if (illegal) begin
                        state_d = ST_RESP;
                    end else if (CSR_read_en | CSR_set_en | CSR_clear_en) begin
                        state_d = ST_READ;
                    end else if (CSR_write_en) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_TRAP_WR: state_d = ST_IDLE;
            ST_READ:    state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                old_d   = csr_rd_data;
                state_d = ST_WRITE;
            end
            ST_WRITE:   state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Outputs are registered: decode them from the state being entered.
        csr_rd_en_d    = (state_d == ST_READ);
        csr_rd_addr_d  = csr_rd_en_d ? addr_d : 12'h000;
        csr_wr_en_d    = (state_d == ST_TRAP_WR) |
                         ((state_d == ST_WRITE) & (op_wr_d | op_set_d | op_clr_d));
        csr_wr_addr_d  = csr_wr_en_d ? addr_d : 12'h000;
        csr_wr_data_d  = '0;
        if (state_d == ST_TRAP_WR) begin
            csr_wr_data_d = wdata_d;
        end else if (csr_wr_en_d) begin
            csr_wr_data_d = new_val;
        end
        pipe_done_d    = (state_d == ST_RESP);
        pipe_rdata_d   = (pipe_done_d & op_rd_d) ? old_d : '0;
        pipe_illegal_d = pipe_done_d & ill_d;

        cycle_d    = cycle_q + 32'd1;
        scan_hit_d = scan & ((cycle_q - SCAN_CYCLES_MIN) <= (SCAN_CYCLES_MAX - SCAN_CYCLES_MIN));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_rd_q        <= 1'b0;
            op_wr_q        <= 1'b0;
            op_set_q       <= 1'b0;
            op_clr_q       <= 1'b0;
            ill_q          <= 1'b0;
            addr_q         <= 12'h000;
            wdata_q        <= '0;
            old_q          <= '0;
            pipe_done_q    <= 1'b0;
            pipe_rdata_q   <= '0;
            pipe_illegal_q <= 1'b0;
            csr_rd_en_q    <= 1'b0;
            csr_rd_addr_q  <= 12'h000;
            csr_wr_en_q    <= 1'b0;
            csr_wr_addr_q  <= 12'h000;
            csr_wr_data_q  <= '0;
            cycle_q        <= 32'd0;
            scan_hit_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_rd_q        <= op_rd_d;
            op_wr_q        <= op_wr_d;
            op_set_q       <= op_set_d;
            op_clr_q       <= op_clr_d;
            ill_q          <= ill_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            old_q          <= old_d;
            pipe_done_q    <= pipe_done_d;
            pipe_rdata_q   <= pipe_rdata_d;
            pipe_illegal_q <= pipe_illegal_d;
            csr_rd_en_q    <= csr_rd_en_d;
            csr_rd_addr_q  <= csr_rd_addr_d;
            csr_wr_en_q    <= csr_wr_en_d;
            csr_wr_addr_q  <= csr_wr_addr_d;
            csr_wr_data_q  <= csr_wr_data_d;
            cycle_q        <= cycle_d;
            scan_hit_q     <= scan_hit_d;
        end
    end

    assign pipe_ready   = accept_pipe;
    assign trap_ready   = accept_trap;
    assign stall        = pipe_valid & ~pipe_done_q & ~reset;
    assign pipe_done    = pipe_done_q;
    assign pipe_rdata   = pipe_rdata_q;
    assign pipe_illegal = pipe_illegal_q;
    assign csr_rd_en    = csr_rd_en_q;
    assign csr_rd_addr  = csr_rd_addr_q;
    assign csr_wr_en    = csr_wr_en_q;
    assign csr_wr_addr  = csr_wr_addr_q;
    assign csr_wr_data  = csr_wr_data_q;

    // Scan-window qualifier for the debug tap; no functional fanout.
    logic scan_unused;
    assign scan_unused = scan_hit_q ^ (^priv) ^ (CORE != 0);

endmodule
